// File: rtl/sd_pkg.sv
// Shared constants and state encoding for the SD card SPI read/init stages.
package sd_pkg;

    // SD command index for READ_SINGLE_BLOCK, with start and transmission bits included
    localparam logic [7:0] CMD17      = 8'h51;
    // Start-of-data token that precedes a single-block payload
    localparam logic [7:0] DATA_TOKEN = 8'hFE;
    // Byte the card sends while it is busy or has nothing to say
    localparam logic [7:0] IDLE_BYTE  = 8'hFF;

    localparam int DEF_DIV_FREQ      = 4;
    localparam int DEF_R1_TIMEOUT    = 64;
    localparam int DEF_TOKEN_TIMEOUT = 50000;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SEND_CMD   = 3'd1,
        WAIT_R1    = 3'd2,
        WAIT_TOKEN = 3'd3,
        READ_DATA  = 3'd4,
        READ_CRC   = 3'd5,
        FINISH     = 3'd6,
        ERROR      = 3'd7
    } sd_state_t;

endpackage

// File: rtl/sd_clk_gen.sv
// SPI clock generator: divides clk_ref down to sd_clk and provides single-cycle
// enables marking the clk_ref cycle on which sd_clk rises or falls.
module sd_clk_gen #(
    parameter int DIV_FREQ = 4
) (
    input  logic clk_ref,
    input  logic rst_n,
    input  logic en,
    output logic sd_clk,
    output logic rise_en,
    output logic fall_en
);

    localparam int HALF = DIV_FREQ / 2;

    logic [31:0] cnt_q, cnt_d;
    logic        sd_clk_q, sd_clk_d;
    logic        toggle;

    // Count half periods while enabled; park the counter and clock low when disabled
    always_comb begin
        toggle   = en && (cnt_q == 32'(HALF - 1));
        cnt_d    = '0;
        sd_clk_d = 1'b0;
        if (en) begin
            if (toggle) begin
                cnt_d    = '0;
                sd_clk_d = ~sd_clk_q;
            end else begin
                cnt_d    = cnt_q + 32'd1;
                sd_clk_d = sd_clk_q;
            end
        end
    end

    // Divider counter and clock level registers
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sd_clk_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sd_clk_q <= sd_clk_d;
        end
    end

    assign sd_clk  = sd_clk_q;
    assign rise_en = toggle & ~sd_clk_q;
    assign fall_en = toggle &  sd_clk_q;

endmodule

// File: rtl/sd_read_sector.sv
// Single-sector SPI read engine: issues CMD17, waits for R1 and the data token,
// streams 512 bytes out one strobe at a time, discards the CRC and releases the card.
module sd_read_sector
    import sd_pkg::*;
#(
    parameter int DIV_FREQ      = DEF_DIV_FREQ,
    parameter int R1_TIMEOUT    = DEF_R1_TIMEOUT,
    parameter int TOKEN_TIMEOUT = DEF_TOKEN_TIMEOUT
) (
    input  logic        clk_ref,
    input  logic        rst_n,
    input  logic        sd_init_done,
    input  logic        rd_start_en,
    input  logic [31:0] rd_sec_addr,
    input  logic        sd_miso,
    output logic        sd_clk,
    output logic        sd_cs,
    output logic        sd_mosi,
    output logic        rd_busy,
    output logic        rd_val_en,
    output logic [7:0]  rd_val_data,
    output logic        rd_err
);

    sd_state_t   state_q, state_d;
    logic [47:0] shift_q, shift_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  rx_q, rx_d;
    logic [2:0]  rx_cnt_q, rx_cnt_d;
    logic [8:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] tmo_q, tmo_d;
    logic        capt_q, capt_d;
    logic        val_en_q, val_en_d;
    logic [7:0]  val_data_q, val_data_d;

    logic        clk_en, rise_en, fall_en;
    logic [7:0]  rx_byte;

    assign clk_en  = (state_q != IDLE);
    assign rx_byte = {rx_q, sd_miso};

    sd_clk_gen #(
        .DIV_FREQ (DIV_FREQ)
    ) u_clk_gen (
        .clk_ref (clk_ref),
        .rst_n   (rst_n),
        .en      (clk_en),
        .sd_clk  (sd_clk),
        .rise_en (rise_en),
        .fall_en (fall_en)
    );

    // State and datapath registers; reset aborts any transfer without flagging an error
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            rx_q       <= '0;
            rx_cnt_q   <= '0;
            byte_cnt_q <= '0;
            tmo_q      <= '0;
            capt_q     <= 1'b0;
            val_en_q   <= 1'b0;
            val_data_q <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            rx_cnt_q   <= rx_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_q      <= tmo_d;
            capt_q     <= capt_d;
            val_en_q   <= val_en_d;
            val_data_q <= val_data_d;
        end
    end

    // Next-state logic: transmit on falling sd_clk, receive on rising sd_clk
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        rx_cnt_d   = rx_cnt_q;
        byte_cnt_d = byte_cnt_q;
        tmo_d      = tmo_q;
        capt_d     = capt_q;
        val_en_d   = 1'b0;
        val_data_d = val_data_q;
        unique case (state_q)
            IDLE: begin
                if (rd_start_en && sd_init_done) begin
                    shift_d    = {CMD17, rd_sec_addr, IDLE_BYTE};
                    bit_cnt_d  = '0;
                    rx_cnt_d   = '0;
                    byte_cnt_d = '0;
                    tmo_d      = '0;
                    capt_d     = 1'b0;
                    state_d    = SEND_CMD;
                end
            end
            SEND_CMD: begin
                if (fall_en) begin
                    if (bit_cnt_q == 6'd47) begin
                        bit_cnt_d = '0;
                        state_d   = WAIT_R1;
                    end else begin
                        shift_d   = {shift_q[46:0], 1'b1};
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
            end
            WAIT_R1: begin
                if (rise_en) begin
                    if (capt_q) begin
                        rx_d     = rx_byte[6:0];
                        rx_cnt_d = rx_cnt_q + 3'd1;
                        if (rx_cnt_q == 3'd7) begin
                            capt_d  = 1'b0;
                            tmo_d   = '0;
                            state_d = (rx_byte == 8'h00) ? WAIT_TOKEN : ERROR;
                        end
                    end else if (!sd_miso) begin
                        capt_d   = 1'b1;
                        rx_d     = '0;
                        rx_cnt_d = 3'd1;
                    end else if (tmo_q >= 32'(R1_TIMEOUT - 1)) begin
                        state_d = ERROR;
                    end else begin
                        tmo_d = tmo_q + 32'd1;
                    end
                end
            end
            WAIT_TOKEN: begin
                if (rise_en) begin
                    rx_d     = rx_byte[6:0];
                    rx_cnt_d = rx_cnt_q + 3'd1;
                    tmo_d    = tmo_q + 32'd1;
                    if (rx_cnt_q == 3'd7 && rx_byte == DATA_TOKEN) begin
                        byte_cnt_d = '0;
                        state_d    = READ_DATA;
                    end else if (rx_cnt_q == 3'd7 && rx_byte != IDLE_BYTE) begin
                        state_d = ERROR;
                    end else if (tmo_q >= 32'(TOKEN_TIMEOUT - 1)) begin
                        state_d = ERROR;
                    end
                end
            end
            READ_DATA: begin
                if (rise_en) begin
                    rx_d     = rx_byte[6:0];
                    rx_cnt_d = rx_cnt_q + 3'd1;
                    if (rx_cnt_q == 3'd7) begin
                        val_en_d   = 1'b1;
                        val_data_d = rx_byte;
                        byte_cnt_d = byte_cnt_q + 9'd1;
                        if (byte_cnt_q == 9'd511) begin
                            bit_cnt_d = '0;
                            state_d   = READ_CRC;
                        end
                    end
                end
            end
            READ_CRC: begin
                if (rise_en) begin
                    if (bit_cnt_q == 6'd15) begin
                        bit_cnt_d = '0;
                        state_d   = FINISH;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
            end
            FINISH: begin
                if (fall_en) begin
                    if (bit_cnt_q == 6'd7) begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
            end
            ERROR: begin
                bit_cnt_d = '0;
                state_d   = FINISH;
            end
        endcase
    end

    // Card-facing and status outputs decoded from the current state
    always_comb begin
        sd_cs   = (state_q == IDLE) || (state_q == FINISH) || (state_q == ERROR);
        sd_mosi = (state_q == SEND_CMD) ? shift_q[47] : 1'b1;
        rd_busy = (state_q != IDLE);
        rd_err  = (state_q == ERROR);
    end

    assign rd_val_en   = val_en_q;
    assign rd_val_data = val_data_q;

endmodule

// File: tb/tb_sd_read_sector.sv
// Directed bench for sd_read_sector with a behavioural SPI card model.
module tb_sd_read_sector;

    logic        clk_ref = 1'b0;
    logic        rst_n = 1'b0;
    logic        sd_init_done = 1'b0;
    logic        rd_start_en = 1'b0;
    logic [31:0] rd_sec_addr = '0;
    logic        sd_miso = 1'b1;
    logic        sd_clk, sd_cs, sd_mosi, rd_busy, rd_val_en, rd_err;
    logic [7:0]  rd_val_data;

    int nCompared = 0;
    int nMismatched = 0;

    int strobeCnt = 0;
    int errCnt = 0;
    int riseCnt = 0;
    int errRiseSnap = 0;
    int cmdCnt = 0;
    int cardMode = 0;
    int cardBits = 0;
    int bitIdx = 0;
    bit streaming = 1'b0;
    logic [7:0]  cardCur;
    logic [47:0] cmdSr = '1;
    logic [47:0] lastCmd = '0;
    logic [7:0]  rxMem [0:4095];

    sd_read_sector #(
        .DIV_FREQ      (4),
        .R1_TIMEOUT    (64),
        .TOKEN_TIMEOUT (100)
    ) dut (
        .clk_ref      (clk_ref),
        .rst_n        (rst_n),
        .sd_init_done (sd_init_done),
        .rd_start_en  (rd_start_en),
        .rd_sec_addr  (rd_sec_addr),
        .sd_miso      (sd_miso),
        .sd_clk       (sd_clk),
        .sd_cs        (sd_cs),
        .sd_mosi      (sd_mosi),
        .rd_busy      (rd_busy),
        .rd_val_en    (rd_val_en),
        .rd_val_data  (rd_val_data),
        .rd_err       (rd_err)
    );

    always #5 clk_ref = ~clk_ref;

    // Byte stream the card sends after the command: mode 0 good read, 1 bad R1, 2 no token
    function automatic logic [7:0] cardByte(input int mode, input int n);
        if (n == 3) return (mode == 1) ? 8'h04 : 8'h00;
        if (mode != 0) return 8'hFF;
        if (n == 14) return 8'hFE;
        if (n >= 15 && n < 527) return 8'((n - 15) % 256);
        if (n == 527) return 8'hA5;
        if (n == 528) return 8'h5A;
        return 8'hFF;
    endfunction

    // Card model: samples mosi on rising sd_clk, drives miso on falling sd_clk
    always @(posedge sd_clk or negedge sd_clk or posedge sd_cs) begin
        if (sd_cs) begin
            cardBits  = 0;
            bitIdx    = 0;
            streaming = 1'b0;
            sd_miso   = 1'b1;
        end else if (sd_clk) begin
            if (!streaming) begin
                cmdSr = {cmdSr[46:0], sd_mosi};
                cardBits++;
                if (cardBits == 48) begin
                    lastCmd = cmdSr;
                    cmdCnt++;
                end
            end
        end else begin
            if (!streaming && cardBits >= 48) begin
                streaming = 1'b1;
                bitIdx    = 0;
            end
            if (streaming) begin
                cardCur = cardByte(cardMode, bitIdx / 8);
                sd_miso = cardCur[7 - (bitIdx % 8)];
                bitIdx++;
            end
        end
    end

    always @(posedge sd_clk) riseCnt++;

    // Record data strobes and error pulses away from the active edge
    always @(negedge clk_ref) begin
        if (rd_val_en) begin
            if (strobeCnt < 4096) rxMem[strobeCnt] = rd_val_data;
            strobeCnt++;
        end
        if (rd_err) begin
            errCnt++;
            errRiseSnap = riseCnt;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr);
        @(negedge clk_ref);
        rd_sec_addr = addr;
        rd_start_en = 1'b1;
        @(negedge clk_ref);
        rd_start_en = 1'b0;
    endtask

    task automatic waitIdle(input int budget, input string tag);
        int n = 0;
        while (rd_busy && n < budget) begin
            @(negedge clk_ref);
            n++;
        end
        checkOutput({tag, "_idle_reached"}, 64'(rd_busy), 64'd0);
    endtask

    task automatic waitStrobes(input int target, input int budget, input string tag);
        int n = 0;
        while (strobeCnt < target && n < budget) begin
            @(negedge clk_ref);
            n++;
        end
        checkOutput({tag, "_strobes_reached"}, 64'(strobeCnt >= target), 64'd1);
    endtask

    task automatic checkReadData(input int base, input string tag);
        int bad = 0;
        for (int i = 0; i < 512; i++) begin
            if (rxMem[base + i] !== 8'(i % 256)) bad++;
        end
        checkOutput({tag, "_data_bad_bytes"}, 64'(bad), 64'd0);
        checkOutput({tag, "_byte0"},   64'(rxMem[base]),       64'h00);
        checkOutput({tag, "_byte255"}, 64'(rxMem[base + 255]), 64'hFF);
        checkOutput({tag, "_byte256"}, 64'(rxMem[base + 256]), 64'h00);
        checkOutput({tag, "_byte511"}, 64'(rxMem[base + 511]), 64'hFF);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_sd_clk"},      64'(sd_clk),      64'd0);
        checkOutput({tag, "_sd_cs"},       64'(sd_cs),       64'd1);
        checkOutput({tag, "_sd_mosi"},     64'(sd_mosi),     64'd1);
        checkOutput({tag, "_rd_busy"},     64'(rd_busy),     64'd0);
        checkOutput({tag, "_rd_val_en"},   64'(rd_val_en),   64'd0);
        checkOutput({tag, "_rd_val_data"}, 64'(rd_val_data), 64'h00);
        checkOutput({tag, "_rd_err"},      64'(rd_err),      64'd0);
    endtask

    initial begin
        int baseStrobe;
        int baseErr;
        int baseCmd;
        int baseRise;

        // Reset values
        repeat (3) @(negedge clk_ref);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk_ref);

        // Request while the card is not initialised is ignored
        applyStimulus(32'h0000_0777);
        repeat (20) @(negedge clk_ref);
        checkOutput("noinit_busy", 64'(rd_busy), 64'd0);
        checkOutput("noinit_cmds", 64'(cmdCnt),  64'd0);

        // Good read of sector 0x1234, with a stray request and init drop mid-read
        sd_init_done = 1'b1;
        cardMode     = 0;
        baseStrobe   = strobeCnt;
        baseErr      = errCnt;
        baseCmd      = cmdCnt;
        applyStimulus(32'h0000_1234);
        checkOutput("read1_busy_rise", 64'(rd_busy), 64'd1);
        checkOutput("read1_cs_low",    64'(sd_cs),   64'd0);
        waitStrobes(baseStrobe + 100, 20000, "read1");
        applyStimulus(32'hDEAD_BEEF);
        sd_init_done = 1'b0;
        waitIdle(40000, "read1");
        sd_init_done = 1'b1;
        checkOutput("read1_cmd_count", 64'(cmdCnt - baseCmd),      64'd1);
        checkOutput("read1_cmd_frame", 64'(lastCmd),               64'h5100001234FF);
        checkOutput("read1_strobes",   64'(strobeCnt - baseStrobe), 64'd512);
        checkOutput("read1_errs",      64'(errCnt - baseErr),       64'd0);
        checkReadData(baseStrobe, "read1");
        checkOutput("read1_cs_end",    64'(sd_cs),  64'd1);
        checkOutput("read1_clk_end",   64'(sd_clk), 64'd0);

        // Card answers R1 = 0x04
        cardMode   = 1;
        baseStrobe = strobeCnt;
        baseErr    = errCnt;
        applyStimulus(32'h0000_0010);
        waitIdle(5000, "r1err");
        checkOutput("r1err_errs",    64'(errCnt - baseErr),       64'd1);
        checkOutput("r1err_strobes", 64'(strobeCnt - baseStrobe), 64'd0);
        checkOutput("r1err_cs",      64'(sd_cs),                  64'd1);

        // Card never sends a token: 48 cmd + 32 R1 + 100 token-wait rises
        cardMode   = 2;
        baseStrobe = strobeCnt;
        baseErr    = errCnt;
        baseRise   = riseCnt;
        applyStimulus(32'h0000_0020);
        waitIdle(5000, "tokto");
        checkOutput("tokto_errs",    64'(errCnt - baseErr),       64'd1);
        checkOutput("tokto_strobes", 64'(strobeCnt - baseStrobe), 64'd0);
        checkOutput("tokto_rises_in_window",
                    64'(((errRiseSnap - baseRise) >= 176) && ((errRiseSnap - baseRise) <= 184)), 64'd1);

        // Reset asserted during byte 200 aborts silently
        cardMode   = 0;
        baseStrobe = strobeCnt;
        baseErr    = errCnt;
        applyStimulus(32'h0000_0055);
        waitStrobes(baseStrobe + 200, 20000, "abort");
        @(negedge clk_ref);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("abort");
        repeat (10) @(negedge clk_ref);
        checkOutput("abort_errs", 64'(errCnt - baseErr), 64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_ref);

        // Fresh read after the abort
        baseStrobe = strobeCnt;
        baseErr    = errCnt;
        baseCmd    = cmdCnt;
        applyStimulus(32'hABCD_0001);
        waitIdle(40000, "read2");
        checkOutput("read2_cmd_count", 64'(cmdCnt - baseCmd),       64'd1);
        checkOutput("read2_cmd_frame", 64'(lastCmd),                64'h51ABCD0001FF);
        checkOutput("read2_strobes",   64'(strobeCnt - baseStrobe), 64'd512);
        checkOutput("read2_errs",      64'(errCnt - baseErr),       64'd0);
        checkReadData(baseStrobe, "read2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/sd_read_sector.md
SD_READ_SECTOR -- requirements
Module: sd_read_sector

Interface
REQ-001 Parameter DIV_FREQ, default 4: clk_ref cycles per sd_clk period; even values >= 2 only.
REQ-002 Parameter R1_TIMEOUT, default 64: maximum sd_clk cycles to wait for the R1 start bit.
REQ-003 Parameter TOKEN_TIMEOUT, default 50000: maximum sd_clk cycles to wait for the data token.
REQ-004 clk_ref  in  1  sole clock; all flops on posedge clk_ref.
REQ-005 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-006 sd_init_done  in  1  card initialised; level from the init stage.
REQ-007 rd_start_en  in  1  one-cycle request to read one sector.
REQ-008 rd_sec_addr  in  32  sector address; sampled on an accepted request.
REQ-009 sd_miso  in  1  card data out.
REQ-010 sd_clk  out  1  SPI clock; idles low.
REQ-011 sd_cs  out  1  chip select; active-low.
REQ-012 sd_mosi  out  1  command data to card.
REQ-013 rd_busy  out  1  high from acceptance through completion.
REQ-014 rd_val_en  out  1  one-cycle strobe per received data byte.
REQ-015 rd_val_data  out  8  received byte; valid while rd_val_en is high.
REQ-016 rd_err  out  1  one-cycle strobe on a failed read.

Function
REQ-017 sd_clk is generated by an internal counter toggling every DIV_FREQ/2 clk_ref cycles, only while state != IDLE; one-cycle rise/fall enables are derived from the counter, with no derived clock domain.
REQ-018 sd_mosi updates on the fall enable; sd_miso is sampled on the rise enable.
REQ-019 A request is accepted only when rd_start_en=1, sd_init_done=1 and state=IDLE; otherwise it is ignored with no effect.
REQ-020 States: IDLE, SEND_CMD, WAIT_R1, WAIT_TOKEN, READ_DATA, READ_CRC, FINISH, ERROR.
REQ-021 IDLE: sd_cs=1, sd_mosi=1, rd_busy=0; an accepted request latches the address, sets rd_busy the next cycle, and moves to SEND_CMD.
REQ-022 SEND_CMD: sd_cs=0; shift out {8'h51, addr[31:0], 8'hFF} MSB first, 48 bits, then go to WAIT_R1.
REQ-023 WAIT_R1: sd_mosi=1; the first sampled 0 starts an 8-bit capture; R1=8'h00 -> WAIT_TOKEN; any other value -> ERROR; no start bit within R1_TIMEOUT -> ERROR.
REQ-024 WAIT_TOKEN: sample byte-aligned; 8'hFE -> READ_DATA; 8'hFF -> keep waiting; any other byte, or TOKEN_TIMEOUT exceeded -> ERROR.
REQ-025 READ_DATA: assemble 512 bytes MSB first; pulse rd_val_en one clk_ref cycle after each eighth bit; a 9-bit byte counter terminates at 511 -> READ_CRC.
REQ-026 READ_CRC: clock in and discard 16 bits -> FINISH; CRC is not checked.
REQ-027 FINISH: sd_cs=1 and mosi=1 for 8 sd_clk cycles -> IDLE; rd_busy falls on entry to IDLE.
REQ-028 ERROR: pulse rd_err once, then perform the FINISH sequence; no rd_val_en is issued after the error.
REQ-029 Exactly 512 rd_val_en pulses per successful read; zero pulses if the error occurs before READ_DATA.
REQ-030 If sd_init_done drops mid-read, the read completes or fails normally; the new state is only checked at the next acceptance.

Reset
REQ-031 During and after reset: state=IDLE, sd_clk=0, sd_cs=1, sd_mosi=1, rd_busy=0, rd_val_en=0, rd_val_data=0, rd_err=0, and all counters 0.
REQ-032 Reset asserted mid-transfer aborts it immediately; no rd_err is pulsed.

Structure
REQ-033 The CMD17 index (8'h51), token 8'hFE, state encodings and default parameter values are defined in a shared package sd_pkg, which the init stage also uses.
REQ-034 sd_clk generation and the edge enables are in one sub-module, sd_clk_gen (inputs: en, DIV_FREQ; outputs: sd_clk, rise_en, fall_en).

Verification
REQ-035 Card model returns R1=00 after 3 FF bytes, token FE after 10 FF bytes, data bytes i mod 256 plus 2 CRC bytes -> mosi shows 51 00 00 12 34 FF for addr 32'h1234, 512 strobes with bytes 00..FF..FF in order, then rd_busy falls.
REQ-036 Card model returns R1=8'h04 -> one rd_err pulse, zero rd_val_en, sd_cs high, state returns to IDLE.
REQ-037 Card model returns only FF after R1 (TOKEN_TIMEOUT=100) -> rd_err after ~100 sd_clk cycles, zero strobes.
REQ-038 rd_start_en pulsed with sd_init_done=0, and pulsed again mid-read -> both requests ignored; the first read's data is unchanged.
REQ-039 rst_n asserted at byte 200 -> all outputs at reset values immediately, no rd_err; a new read then completes correctly.
